bus_arbiter_3x1: RTL

BUS_ARBITER_3X1 -- requirements
Module: bus_arbiter_3x1

---
 rtl/bus_arbiter_3x1.sv | 119 +++++++++++
 1 files changed

// File: rtl/bus_arbiter_3x1.sv
// Three-source round-robin bus arbiter with one-cycle grant latency,
// per-grant beat limit, end-of-burst release and request-withdrawal abort.
module bus_arbiter_3x1 #(
  parameter int MAX_BEATS = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req_in,
  input  logic [2:0] last_in,
  input  logic       bus_ready_in,
  output logic [1:0] select_3x1,
  output logic [2:0] grant_out,
  output logic       bus_valid_out,
  output logic       busy_out,
  output logic       abort_out
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_BEATS);

  state_e               state_q, state_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           grant_q, grant_d;
  logic                 abort_q, abort_d;

  logic [1:0]           gidx, next_ptr, k;
  logic [2:0]           pick;
  logic                 found, req_g, last_g, valid;
  logic [CNT_WIDTH-1:0] cnt_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      grant_q <= 3'b000;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      abort_q <= abort_d;
    end
  end

  // Granted index is recovered from the one-hot grant; zero grant maps to 0.
  always_comb begin
    case (grant_q)
      3'b010:  gidx = 2'd1;
      3'b100:  gidx = 2'd2;
      default: gidx = 2'd0;
    endcase
    next_ptr = (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
    req_g    = |(req_in & grant_q);
    last_g   = |(last_in & grant_q);
    valid    = (state_q == GRANT) && req_g;
    cnt_inc  = cnt_q + CNT_WIDTH'(1);
  end

  // Round-robin scan starting at the pointer, wrapping 2 -> 0.
  always_comb begin
    pick  = 3'b000;
    found = 1'b0;
    k     = 2'd0;
    for (int i = 0; i < 3; i++) begin
      k = 2'((int'(ptr_q) + i) % 3);
      if (!found && req_in[k]) begin
        pick[k] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    abort_d = 1'b0;
    if (state_q == IDLE) begin
      if (found) begin
        state_d = GRANT;
        grant_d = pick;
        cnt_d   = '0;
      end
    end else begin
      if (!req_g) begin
        state_d = IDLE;
        grant_d = 3'b000;
        cnt_d   = '0;
        ptr_d   = next_ptr;
        abort_d = 1'b1;
      end else if (bus_ready_in) begin
        // last_in and the beat limit together still give one plain release.
        if (last_g || (cnt_inc == MAX_CNT)) begin
          state_d = IDLE;
          grant_d = 3'b000;
          cnt_d   = '0;
          ptr_d   = next_ptr;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    end
  end

  always_comb begin
    grant_out     = grant_q;
    select_3x1    = gidx;
    busy_out      = (state_q == GRANT);
    bus_valid_out = valid;
    abort_out     = abort_q;
  end

endmodule
